// File: rtl/fetch_buffer_if.sv
// ---------------------------------------------------------------------------
// fetch_buffer_if
//   Instruction-memory request channel between the fetch buffer (master) and
//   instruction memory (slave). At most one request is outstanding. The
//   master holds imem_valid/imem_addr stable until a cycle with
//   imem_ready=1, and imem_rdata is valid in that same cycle.
//
//   imem_valid  master->slave  request valid
//   imem_addr   master->slave  word address of the request (bits[1:0]==0)
//   imem_ready  slave->master  request completes this cycle
//   imem_rdata  slave->master  returned instruction word
// ---------------------------------------------------------------------------
interface fetch_buffer_if;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_valid,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_valid,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//   Instruction fetch / prefetch stage in front of the decoder. Issues
//   sequential word reads to instruction memory (one outstanding request),
//   stores returned words with their PCs in a DEPTH-entry FIFO and presents
//   the FIFO head to the decoder. A redirect from execute flushes the FIFO
//   and restarts fetch at the new target; a response that is in flight at
//   the time of the redirect is dropped.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-low reset
//   imem           instruction-memory request channel (master side)
//   redirect       flush and restart fetch at redirect_addr
//   redirect_addr  new PC; bits[1:0] are ignored
//   stall          decoder is not accepting the head this cycle
//   instr_valid    head entry valid
//   instr          head instruction, nop (32'h00000013) when not valid
//   pc             head PC, 0 when not valid
// ---------------------------------------------------------------------------
module fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clock,
  input  logic                reset,
  fetch_buffer_if.master      imem,
  input  logic                redirect,
  input  logic [31:0]         redirect_addr,
  input  logic                stall,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [31:0]         pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // IDLE: nothing outstanding. REQ: outstanding, response will be kept.
  // KILL: outstanding, response belongs to a flushed stream and is dropped.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t           state, state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      target_pc;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_next;
  entry_t           fifo_mem [DEPTH];
  entry_t           head;

  logic             push;
  logic             pop;
  logic             room;
  logic             issue;
  logic [31:0]      issue_addr;

  // Low address bits of the redirect target are discarded by design.
  logic             unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_addr[1:0];

  assign target_pc = {redirect_addr[31:2], 2'b00};

  // The head is only consumed when the decoder takes it and no flush is
  // happening; a redirect wins over both stall and the normal pop.
  assign pop = instr_valid && !stall && !redirect;

  // Occupancy after this cycle's push/pop/flush. Issue is allowed only if
  // that leaves room, so the returned word always has a slot waiting.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; otherwise a latch would be inferred.
    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end
  end

  assign room = (count_next < CNT_W'(DEPTH));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (redirect || room) state_next = REQ;
      end
      REQ: begin
        if (redirect) begin
          // Completing now: drop the word and go straight to the target.
          // Still waiting: the eventual response must be discarded.
          state_next = imem.imem_ready ? REQ : KILL;
        end else if (imem.imem_ready) begin
          state_next = room ? REQ : IDLE;
        end
      end
      KILL: begin
        // A redirect here only retargets fetch_pc; the stale request is
        // still outstanding and must finish first.
        if (!redirect && imem.imem_ready) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (push into FIFO, issue of a new request and its address)
  // -------------------------------------------------------------------------
  always_comb begin
    push       = 1'b0;
    issue      = 1'b0;
    issue_addr = redirect ? target_pc : fetch_pc;
    unique case (state)
      IDLE: begin
        issue = redirect || room;
      end
      REQ: begin
        if (imem.imem_ready) begin
          push  = !redirect;
          issue = redirect || room;
        end
      end
      KILL: begin
        issue = !redirect && imem.imem_ready;
      end
      default: begin
        push  = 1'b0;
        issue = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request registers, fetch PC and FIFO pointers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      imem.imem_valid <= 1'b0;
      imem.imem_addr  <= 32'h0;
      fetch_pc        <= RESET_PC;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
    end else begin
      // A request is outstanding exactly when the FSM is not IDLE; the
      // address only moves on issue, so it holds while a request pends.
      imem.imem_valid <= (state_next != IDLE);
      if (issue) begin
        imem.imem_addr <= issue_addr;
        fetch_pc       <= issue_addr + 32'd4;
      end else if (redirect) begin
        fetch_pc <= target_pc;
      end

      count <= count_next;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // NOTE: the FIFO storage has no reset; validity is carried entirely by
  // count, so stale contents are never observable.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{pc: imem.imem_addr, instr: imem.imem_rdata};
    end
  end

  // -------------------------------------------------------------------------
  // Decoder-side outputs: registered head, no bypass from imem_rdata.
  // -------------------------------------------------------------------------
  assign head        = fifo_mem[rd_ptr];
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head.instr : NOP;
  assign pc          = instr_valid ? head.pc    : 32'h0;

endmodule

// File: tb/tb_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_buffer
//   Directed bench for fetch_buffer (DEPTH=4, RESET_PC=0). Memory returns
//   addr ^ 32'hA5A5A5A5; imem_ready is driven step by step to shape latency.
//   Inputs are changed 1 time unit after a rising edge and outputs are
//   sampled at the same point, so each step below is one clock cycle.
// ---------------------------------------------------------------------------
module tb_fetch_buffer;

  localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;

  int tests;
  int fails;

  fetch_buffer_if imem ();

  fetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem          (imem),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .stall         (stall),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc            (pc)
  );

  // Memory data is a fixed function of the requested address.
  assign imem.imem_rdata = imem.imem_addr ^ XOR_KEY;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Head of the buffer: valid flag, pc and instr (nop/0 when empty).
  task automatic check_head(input string tag, input logic v, input logic [31:0] p);
    check({tag, " instr_valid"}, 32'(instr_valid), 32'(v));
    check({tag, " pc"},          pc,    v ? p : 32'h0);
    check({tag, " instr"},       instr, v ? (p ^ XOR_KEY) : NOP);
  endtask

  task automatic check_req(input string tag, input logic v, input logic [31:0] a);
    check({tag, " imem_valid"}, 32'(imem.imem_valid), 32'(v));
    check({tag, " imem_addr"},  imem.imem_addr, a);
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    reset           = 1'b0;
    redirect        = 1'b0;
    redirect_addr   = 32'h0;
    stall           = 1'b0;
    imem.imem_ready = 1'b0;

    // ---- Reset values ----------------------------------------------------
    step();
    check_req("reset", 1'b0, 32'h0);
    check_head("reset", 1'b0, 32'h0);

    // ---- Zero-wait memory, no stall: cycle 0 is first cycle out of reset -
    reset           = 1'b1;
    imem.imem_ready = 1'b1;
    step();                                   // cycle 1
    check_req("c1", 1'b1, 32'h0);
    check_head("c1", 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin         // cycles 2..7
      step();
      check_req($sformatf("zw%0d", i), 1'b1, 32'(4 * (i + 1)));
      check_head($sformatf("zw%0d", i), 1'b1, 32'(4 * i));
    end

    // ---- Stall for 10 cycles (7..16): buffer fills to 4, fetch stops -----
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin        // cycles 8..17
      step();
      check_head($sformatf("stall%0d", i), 1'b1, 32'd20);
      if (i >= 2) check($sformatf("stall%0d full imem_valid", i), 32'(imem.imem_valid), 32'd0);
    end
    stall = 1'b0;                             // cycle 17 pops pc=20
    for (int i = 0; i < 8; i++) begin         // cycles 18..25
      step();
      check_head($sformatf("drain%0d", i), 1'b1, 32'(24 + 4 * i));
      check_req($sformatf("drain%0d", i), 1'b1, 32'(36 + 4 * i));
    end

    // ---- Redirect to 0x203 with imem_ready=1 and stall=1 (cycle 25) ------
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0203;
    stall         = 1'b1;
    step();                                   // cycle 26
    check_req("redir203", 1'b1, 32'h200);
    check_head("redir203", 1'b0, 32'h0);

    // ---- 3-cycle latency, redirect one cycle after issue -----------------
    redirect        = 1'b0;
    stall           = 1'b0;
    imem.imem_ready = 1'b0;
    step();                                   // cycle 27
    check_req("lat_wait", 1'b1, 32'h200);
    check_head("lat_wait", 1'b0, 32'h0);
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0100;
    step();                                   // cycle 28: KILL, addr holds
    check_req("kill_hold", 1'b1, 32'h200);
    check_head("kill_hold", 1'b0, 32'h0);
    redirect        = 1'b0;
    imem.imem_ready = 1'b1;                   // stale 0x200 response arrives
    step();                                   // cycle 29
    check_req("kill_reissue", 1'b1, 32'h100);
    check_head("kill_drop", 1'b0, 32'h0);
    imem.imem_ready = 1'b0;
    step();                                   // cycle 30
    check_req("t100_wait1", 1'b1, 32'h100);
    check_head("t100_wait1", 1'b0, 32'h0);
    step();                                   // cycle 31
    check_head("t100_wait2", 1'b0, 32'h0);
    imem.imem_ready = 1'b1;
    step();                                   // cycle 32
    check_head("t100_out", 1'b1, 32'h100);
    check_req("t100_next", 1'b1, 32'h104);

    // ---- Redirect while pending, then again while in KILL ----------------
    imem.imem_ready = 1'b0;
    redirect        = 1'b1;
    redirect_addr   = 32'h0000_0300;
    step();                                   // cycle 33: KILL
    check_req("kill2", 1'b1, 32'h104);
    check_head("kill2_flush", 1'b0, 32'h0);
    redirect_addr = 32'h0000_0404;            // retarget inside KILL
    step();                                   // cycle 34
    check_req("kill2_retarget", 1'b1, 32'h104);
    redirect        = 1'b0;
    imem.imem_ready = 1'b1;
    step();                                   // cycle 35
    check_req("kill2_reissue", 1'b1, 32'h404);
    check_head("kill2_drop", 1'b0, 32'h0);

    // ---- Reset while in KILL with imem_valid=1 ---------------------------
    imem.imem_ready = 1'b0;
    redirect        = 1'b1;
    redirect_addr   = 32'h0000_0500;
    step();                                   // cycle 36: KILL
    check_req("kill3", 1'b1, 32'h404);
    redirect        = 1'b0;
    reset           = 1'b0;
    imem.imem_ready = 1'b1;
    step();                                   // cycle 37
    check_req("rst_kill", 1'b0, 32'h0);
    check_head("rst_kill", 1'b0, 32'h0);
    reset = 1'b1;
    step();                                   // cycle 38
    check_req("refetch", 1'b1, 32'h0);
    step();                                   // cycle 39
    check_head("refetch", 1'b1, 32'h0);
    check_req("refetch_next", 1'b1, 32'h4);

    // ---- Fill to full, then redirect from IDLE ---------------------------
    stall = 1'b1;
    step();                                   // cycle 40
    step();                                   // cycle 41
    step();                                   // cycle 42: full, IDLE
    check_req("full_idle", 1'b0, 32'hC);
    check_head("full_idle", 1'b1, 32'h0);
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0600;
    step();                                   // cycle 43
    check_req("idle_redir", 1'b1, 32'h600);
    check_head("idle_redir", 1'b0, 32'h0);
    redirect = 1'b0;
    stall    = 1'b0;
    step();                                   // cycle 44 = T+2
    check_head("idle_redir_t2", 1'b1, 32'h600);
    check_req("idle_redir_t2", 1'b1, 32'h604);
    step();                                   // cycle 45
    check_head("idle_redir_t3", 1'b1, 32'h604);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
